// File: rtl/des_key_pkg.sv
// DES key-schedule shared definitions: PC-1/PC-2 index tables, rotation
// schedule, FSM state type and the helpers that turn a schedule position
// into a rotation amount.
package des_key_pkg;

  localparam int RK_W = 48;

  // C/D bit k (1-based) is key bit PC1[k-1]
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // round-key bit k (1-based) is C/D bit PC2[k-1]
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // total rotation over rounds first..last (inclusive); loop bounds are
  // fixed so the function stays synthesizable with run-time arguments
  function automatic int shift_sum(input int first, input int last);
    int s;
    s = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i >= first && i <= last) s += SHIFT[i];
    end
    return s;
  endfunction

  // rotation applied before emitting schedule position pos (1..16).
  // Decrypt starts from C0/D0, which already equals C16/D16, so the first
  // position needs no rotation and later ones undo the encrypt shifts.
  function automatic logic [1:0] lane_shift(input int pos, input logic dec);
    logic [1:0] a;
    if (!dec)          a = 2'(shift_sum(pos, pos));
    else if (pos == 1) a = 2'd0;
    else               a = 2'(shift_sum(18 - pos, 18 - pos));
    return a;
  endfunction

endpackage

// File: rtl/des_key_sched_if.sv
// Key-load and round-key stream bundle for des_key_sched.
// Bit n of key_in is DES key bit n (bit 1 = leftmost); lane l of rk_data
// occupies [48*l+48:48*l+1] with the same per-lane numbering.
interface des_key_sched_if
  import des_key_pkg::*;
#(
  parameter int LANES = 1
) ();

  logic [64:1]         key_in;
  logic                key_decrypt;
  logic                key_valid;
  logic                key_ready;
  logic                key_abort;
  logic [RK_W*LANES:1] rk_data;
  logic [3:0]          rk_idx;
  logic                rk_valid;
  logic                rk_last;
  logic                rk_ready;
  logic                parity_err;

  modport master (
    output key_in, key_decrypt, key_valid, key_abort, rk_ready,
    input  key_ready, rk_data, rk_idx, rk_valid, rk_last, parity_err
  );

  modport slave (
    input  key_in, key_decrypt, key_valid, key_abort, rk_ready,
    output key_ready, rk_data, rk_idx, rk_valid, rk_last, parity_err
  );

endinterface

// File: rtl/des_key_round.sv
// One key-schedule step: rotate C and D by 0/1/2 positions (left for
// encrypt, right for decrypt) and form the 48-bit round key with PC-2.
// Purely combinational; chained LANES times in des_key_sched.
module des_key_round
  import des_key_pkg::*;
(
  input  logic [28:1]   i_c,
  input  logic [28:1]   i_d,
  input  logic          i_dir_right,
  input  logic [1:0]    i_amt,
  output logic [28:1]   o_c,
  output logic [28:1]   o_d,
  output logic [RK_W:1] o_rk
);

  // bit 1 is the DES-leftmost bit, so a DES left rotate moves bits
  // toward lower indices
  function automatic logic [28:1] rot28(input logic [28:1] v, input logic right,
                                        input logic [1:0] amt);
    logic [28:1] r;
    r = v;
    if (right) begin
      if (amt == 2'd1)      r = {v[27:1], v[28]};
      else if (amt == 2'd2) r = {v[26:1], v[28:27]};
    end else begin
      if (amt == 2'd1)      r = {v[1], v[28:2]};
      else if (amt == 2'd2) r = {v[2:1], v[28:3]};
    end
    return r;
  endfunction

  logic [56:1] w_cd;

  assign o_c  = rot28(i_c, i_dir_right, i_amt);
  assign o_d  = rot28(i_d, i_dir_right, i_amt);
  assign w_cd = {o_d, o_c};

  // PC-2 selection from the rotated halves
  always_comb begin
    o_rk = '0;
    for (int k = 1; k <= RK_W; k++) o_rk[k] = w_cd[PC2[k-1]];
  end

endmodule

// File: rtl/des_key_sched.sv
// Sequential DES key-schedule engine: accepts a 64-bit key, applies PC-1,
// then streams the 16 round keys LANES per beat, K1..K16 or K16..K1.
// Optional build macro: DES_KEY_PARITY_CHK_EN (odd-parity check per key
// byte; a failing key is consumed, parity_err pulses, nothing is emitted).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | key_ready=1, waiting for a key
// RUN   | rk_valid=1, streaming beats; C/D advance on each handshake
module des_key_sched
  import des_key_pkg::*;
#(
  parameter int LANES = 1
) (
  input logic            clk,
  input logic            rst_n,
  des_key_sched_if.slave bus
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("des_key_sched: LANES must be 1, 2 or 4");
  end

  state_t r_state;
  state_t w_state_nxt;
  logic   w_key_ready;
  logic   w_rk_valid;

  logic [28:1] r_c;
  logic [28:1] r_d;
  logic        r_dec;
  logic [3:0]  r_pos;

  logic [56:1]         w_pc1;
  logic [28:1]         w_c [0:LANES];
  logic [28:1]         w_d [0:LANES];
  logic [RK_W*LANES:1] w_rk;
  logic                w_last;
  logic                w_accept;
  logic                w_fire;
  logic                w_par_ok;

  // PC-1 of the offered key; C0 = bits 1..28, D0 = bits 29..56
  always_comb begin
    w_pc1 = '0;
    for (int k = 1; k <= 56; k++) w_pc1[k] = bus.key_in[PC1[k-1]];
  end

`ifdef DES_KEY_PARITY_CHK_EN
  logic r_parity_err;

  // every key byte must carry odd parity
  always_comb begin
    w_par_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (!(^bus.key_in[8*b+1 +: 8])) w_par_ok = 1'b0;
    end
  end

  // one-cycle error pulse after a rejected key is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_parity_err <= 1'b0;
    else        r_parity_err <= w_accept && !w_par_ok;
  end

  assign bus.parity_err = r_parity_err;
`else
  logic w_unused_parity;

  assign w_par_ok        = 1'b1;
  assign w_unused_parity = ^{bus.key_in[64], bus.key_in[56], bus.key_in[48], bus.key_in[40],
                             bus.key_in[32], bus.key_in[24], bus.key_in[16], bus.key_in[8]};
  assign bus.parity_err  = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && bus.key_valid && !bus.key_abort;
  assign w_fire   = (r_state == RUN) && bus.rk_ready && !bus.key_abort;
  assign w_last   = (r_pos == 4'(16 - LANES));

  // rotation chain: lane l emits schedule position r_pos+l+1
  assign w_c[0] = r_c;
  assign w_d[0] = r_d;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [1:0] w_amt;

    assign w_amt = lane_shift(int'(r_pos) + l + 1, r_dec);

    des_key_round u_round (
      .i_c         (w_c[l]),
      .i_d         (w_d[l]),
      .i_dir_right (r_dec),
      .i_amt       (w_amt),
      .o_c         (w_c[l+1]),
      .o_d         (w_d[l+1]),
      .o_rk        (w_rk[RK_W*l+1 +: RK_W])
    );
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // next state and handshake outputs; abort wins over a beat handshake
  always_comb begin
    w_state_nxt = r_state;
    w_key_ready = 1'b0;
    w_rk_valid  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_key_ready = 1'b1;
        if (w_accept && w_par_ok) w_state_nxt = RUN;
      end
      RUN: begin
        w_rk_valid = 1'b1;
        if (bus.key_abort)                w_state_nxt = IDLE;
        else if (bus.rk_ready && w_last)  w_state_nxt = IDLE;
      end
    endcase
  end

  // C/D, mode and position: load on accept, advance only on a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c   <= '0;
      r_d   <= '0;
      r_dec <= 1'b0;
      r_pos <= '0;
    end else if (w_accept && w_par_ok) begin
      r_c   <= w_pc1[28:1];
      r_d   <= w_pc1[56:29];
      r_dec <= bus.key_decrypt;
      r_pos <= '0;
    end else if (w_fire) begin
      r_c   <= w_c[LANES];
      r_d   <= w_d[LANES];
      r_pos <= r_pos + 4'(LANES);
    end
  end

  assign bus.key_ready = w_key_ready;
  assign bus.rk_valid  = w_rk_valid;
  assign bus.rk_last   = w_rk_valid && w_last;
  assign bus.rk_idx    = w_rk_valid ? (r_dec ? (4'd15 - r_pos) : r_pos) : 4'd0;
  assign bus.rk_data   = w_rk_valid ? w_rk : '0;

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched: a LANES=1 and a LANES=4 instance
// share one stimulus path; results are compared against a bit-level DES
// key-schedule model written in standard (leftmost = bit 1) notation.
module tb_des_key_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  des_key_sched_if #(.LANES(1)) if1 ();
  des_key_sched_if #(.LANES(4)) if4 ();

  des_key_sched #(.LANES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  des_key_sched #(.LANES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  logic        sel4;
  logic [64:1] tb_key;
  logic        tb_kv, tb_dec, tb_abort, tb_rr;

  assign if1.key_in      = tb_key;
  assign if1.key_decrypt = tb_dec;
  assign if1.key_valid   = tb_kv & ~sel4;
  assign if1.key_abort   = tb_abort & ~sel4;
  assign if1.rk_ready    = tb_rr;
  assign if4.key_in      = tb_key;
  assign if4.key_decrypt = tb_dec;
  assign if4.key_valid   = tb_kv & sel4;
  assign if4.key_abort   = tb_abort & sel4;
  assign if4.rk_ready    = tb_rr;

  logic [191:0] o_data;
  logic [3:0]   o_idx;
  logic         o_valid, o_last, o_kready, o_perr;

  assign o_data   = sel4 ? if4.rk_data : {144'd0, if1.rk_data};
  assign o_idx    = sel4 ? if4.rk_idx : if1.rk_idx;
  assign o_valid  = sel4 ? if4.rk_valid : if1.rk_valid;
  assign o_last   = sel4 ? if4.rk_last : if1.rk_last;
  assign o_kready = sel4 ? if4.key_ready : if1.key_ready;
  assign o_perr   = sel4 ? if4.parity_err : if1.parity_err;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  localparam int M_PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int M_PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                                23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int M_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic [47:0] exp_rk [16];

  // standard DES key schedule: exp_rk[r] = K(r+1), leftmost bit = MSB
  task automatic model_keys(input logic [63:0] k);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [55:0] cdi;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-M_PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      c = (c << M_SH[r]) | (c >> (28 - M_SH[r]));
      d = (d << M_SH[r]) | (d >> (28 - M_SH[r]));
      cdi = {c, d};
      for (int i = 0; i < 48; i++) exp_rk[r][47-i] = cdi[56-M_PC2[i]];
    end
  endtask

  function automatic logic [63:0] rev64(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = v[63-i];
    return r;
  endfunction

  function automatic logic [47:0] rev48(input logic [47:0] v);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[i] = v[47-i];
    return r;
  endfunction

  function automatic logic [63:0] rand_key();
    logic [63:0] k;
    k = {$urandom, $urandom};
    for (int b = 0; b < 8; b++) if (!(^k[8*b +: 8])) k[8*b] = ~k[8*b];
    return k;
  endfunction

  // load one key and follow its schedule; rdy_pct<0 alternates rk_ready,
  // kill_at>=0 aborts (or resets, when kill_rst) on that beat
  task automatic run_key(input logic [63:0] kstd, input bit dec, input int rdy_pct,
                         input int kill_at, input bit kill_rst);
    int lanes, nbeats, b, cyc, j, ki;
    logic [191:0] expv;
    lanes  = sel4 ? 4 : 1;
    nbeats = 16 / lanes;
    model_keys(kstd);
    @(negedge clk);
    chk("key_ready idle", o_kready, 1);
    tb_key = rev64(kstd); tb_dec = dec; tb_kv = 1'b1; tb_rr = 1'b0;
    @(negedge clk);
    tb_kv = 1'b0; tb_key = {$urandom, $urandom}; tb_dec = 1'($urandom_range(1));
    chk("parity_err quiet", o_perr, 0);
    chk("key_ready busy", o_kready, 0);
    b = 0; cyc = 0;
    while (b < nbeats && cyc < 200) begin
      cyc++;
      chk("rk_valid", o_valid, 1);
      if (o_valid !== 1'b1) break;
      expv = '0;
      for (int l = 0; l < lanes; l++) begin
        j  = b * lanes + l;
        ki = dec ? 15 - j : j;
        expv[48*l +: 48] = rev48(exp_rk[ki]);
      end
      chk("rk_data", o_data, expv);
      chk("rk_idx", o_idx, dec ? 15 - b * lanes : b * lanes);
      chk("rk_last", o_last, (b == nbeats - 1));
      if (rdy_pct == 100 && b == nbeats - 1) chk("last beat latency", cyc, nbeats);
      if (b == kill_at) begin
        if (kill_rst) begin
          rst_n = 1'b0;
          #1;
          chk("rst rk_valid", o_valid, 0);
          chk("rst rk_data", o_data, 0);
          chk("rst rk_idx", o_idx, 0);
          chk("rst rk_last", o_last, 0);
          chk("rst key_ready", o_kready, 1);
          @(negedge clk);
          rst_n = 1'b1;
          tb_rr = 1'b0;
          @(negedge clk);
          chk("post-rst key_ready", o_kready, 1);
          chk("post-rst rk_valid", o_valid, 0);
        end else begin
          tb_abort = 1'b1; tb_rr = 1'b1;
          @(negedge clk);
          tb_abort = 1'b0; tb_rr = 1'b0;
          chk("abort rk_valid", o_valid, 0);
          chk("abort key_ready", o_kready, 1);
        end
        return;
      end
      tb_rr = (rdy_pct < 0) ? (cyc % 2 == 1) : ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (tb_rr) b++;
    end
    if (b < nbeats) chk("schedule completed", b, nbeats);
    tb_rr = 1'b0;
    chk("done rk_valid", o_valid, 0);
    chk("done key_ready", o_kready, 1);
  endtask

  localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;

  initial begin
    rst_n = 1'b0; sel4 = 1'b0; tb_key = '0; tb_kv = 1'b0; tb_dec = 1'b0;
    tb_abort = 1'b0; tb_rr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset key_ready", o_kready, 1);
    chk("reset rk_valid", o_valid, 0);
    chk("reset rk_last", o_last, 0);
    chk("reset rk_idx", o_idx, 0);
    chk("reset rk_data", o_data, 0);
    chk("reset parity_err", o_perr, 0);
    rst_n = 1'b1;

    model_keys(KEY_STD);
    chk("model K1", {144'd0, exp_rk[0]}, {144'd0, 48'h1B02EFFC7072});
    chk("model K16", {144'd0, exp_rk[15]}, {144'd0, 48'hCB3D8B0E17F5});

    // LANES=1: reference vector both directions, then random keys/backpressure
    run_key(KEY_STD, 1'b0, 100, -1, 1'b0);
    run_key(KEY_STD, 1'b1, 100, -1, 1'b0);
    for (int i = 0; i < 4; i++) run_key(rand_key(), 1'($urandom_range(1)), 60, -1, 1'b0);

    // LANES=4: alternating ready on the reference key, then random
    sel4 = 1'b1;
    run_key(KEY_STD, 1'b0, -1, -1, 1'b0);
    run_key(KEY_STD, 1'b1, 100, -1, 1'b0);
    for (int i = 0; i < 3; i++) run_key(rand_key(), 1'($urandom_range(1)), 50, -1, 1'b0);
    sel4 = 1'b0;

    // abort on beat 5 with a simultaneous handshake, then a clean restart
    run_key(KEY_STD, 1'b0, 100, 5, 1'b0);
    run_key(rand_key(), 1'b0, 100, -1, 1'b0);

    // abort while idle blocks acceptance
    @(negedge clk);
    tb_key = rev64(KEY_STD); tb_kv = 1'b1; tb_abort = 1'b1;
    @(negedge clk);
    tb_kv = 1'b0; tb_abort = 1'b0;
    chk("idle abort no run", o_valid, 0);
    chk("idle abort key_ready", o_kready, 1);

    // reset pulse in the middle of a decrypt schedule, then recovery
    run_key(rand_key(), 1'b1, 100, 3, 1'b1);
    run_key(KEY_STD, 1'b0, 100, -1, 1'b0);

`ifdef DES_KEY_PARITY_CHK_EN
    @(negedge clk);
    tb_key = rev64(64'h123457799BBCDFF1); tb_kv = 1'b1; tb_dec = 1'b0;
    @(negedge clk);
    tb_kv = 1'b0;
    chk("parity_err pulse", o_perr, 1);
    chk("parity reject no run", o_valid, 0);
    chk("parity reject key_ready", o_kready, 1);
    @(negedge clk);
    chk("parity_err one cycle", o_perr, 0);
    chk("parity reject still idle", o_valid, 0);
    run_key(KEY_STD, 1'b0, 100, -1, 1'b0);
`else
    run_key(64'h123457799BBCDFF1, 1'b0, 100, -1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
